// File: rtl/axi_lite_arbiter.sv
// Two-requester AXI-Lite master arbiter: grants one local request at a time
// and runs a single-beat AXI-Lite read or write for it.
// Ports: clk, resetn (sync, active-low); req0_*/req1_* valid/write/addr/wdata
// in, ready/done/rdata/resp out; m_aw*/m_w*/m_b*/m_ar*/m_r* AXI-Lite master.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (req0 wins ties);
// round-robin when undefined.
module axi_lite_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    output logic [1:0]        req0_resp,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [1:0]        req1_resp,
    output logic              m_awvalid,
    output logic [ADDR_W-1:0] m_awaddr,
    input  logic              m_awready,
    output logic              m_wvalid,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_wready,
    input  logic              m_bvalid,
    input  logic [1:0]        m_bresp,
    output logic              m_bready,
    output logic              m_arvalid,
    output logic [ADDR_W-1:0] m_araddr,
    input  logic              m_arready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    output logic              m_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_RESP
    } state_t;

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                idx_q, idx_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic [1:0]          resp0_q, resp0_d;
    logic [1:0]          resp1_q, resp1_d;
`ifndef ARB_FIXED_PRIO_EN
    // 1 means req1 held the most recent grant
    logic                last_grant_q, last_grant_d;
`endif

    logic gnt0, gnt1, accept;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    always_comb begin
`ifdef ARB_FIXED_PRIO_EN
        gnt0 = req0_valid;
`else
        gnt0 = req0_valid && (!req1_valid || last_grant_q);
`endif
        gnt1 = req1_valid && !gnt0;
    end

    assign req0_ready = (state_q == IDLE) && gnt0 && resetn;
    assign req1_ready = (state_q == IDLE) && gnt1 && resetn;
    assign accept     = req0_ready || req1_ready;

    // AXI valids come only from registered state, never from a ready
    assign m_awvalid = (state_q == WR_ADDR) && !aw_done_q;
    assign m_wvalid  = (state_q == WR_ADDR) && !w_done_q;
    assign m_bready  = (state_q == WR_RESP);
    assign m_arvalid = (state_q == RD_ADDR);
    assign m_rready  = (state_q == RD_RESP);
    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_wdata   = wdata_q;

    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;
    assign b_hs  = m_bvalid && m_bready;
    assign ar_hs = m_arvalid && m_arready;
    assign r_hs  = m_rvalid && m_rready;

    assign req0_done  = done0_q;
    assign req1_done  = done1_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;
    assign req0_resp  = resp0_q;
    assign req1_resp  = resp1_q;

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        idx_d     = idx_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        resp0_d   = resp0_q;
        resp1_d   = resp1_q;
`ifndef ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_d      = gnt1 ? req1_write : req0_write;
                    addr_d    = gnt1 ? req1_addr  : req0_addr;
                    wdata_d   = gnt1 ? req1_wdata : req0_wdata;
                    idx_d     = gnt1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = wr_d ? WR_ADDR : RD_ADDR;
`ifndef ARB_FIXED_PRIO_EN
                    last_grant_d = gnt1;
`endif
                end
            end
            WR_ADDR: begin
                // aw and w complete independently, possibly together
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_d = IDLE;
                    if (idx_q) begin
                        done1_d = 1'b1;
                        resp1_d = m_bresp;
                    end else begin
                        done0_d = 1'b1;
                        resp0_d = m_bresp;
                    end
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (r_hs) begin
                    state_d = IDLE;
                    if (idx_q) begin
                        done1_d  = 1'b1;
                        rdata1_d = m_rdata;
                        resp1_d  = m_rresp;
                    end else begin
                        done0_d  = 1'b1;
                        rdata0_d = m_rdata;
                        resp0_d  = m_rresp;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            idx_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            resp0_q   <= '0;
            resp1_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            idx_q     <= idx_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            resp0_q   <= resp0_d;
            resp1_q   <= resp1_d;
`ifndef ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

endmodule
